// File: rtl/multu_pkg.sv
// -----------------------------------------------------------------------------
// multu_pkg
//   Shared definitions for the iterative unsigned multiplier (MULTU) block.
//   Contents:
//     MULTU_WIDTH  - default operand width (product is 2*MULTU_WIDTH)
//     MULTU_CNT_W  - default iteration counter width
//     state_t      - sequencer state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
package multu_pkg;

  localparam int MULTU_WIDTH = 32;
  localparam int MULTU_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_datapath.sv
// -----------------------------------------------------------------------------
// multu_datapath
//   Shift-add datapath for the MULTU sequencer: multiplicand, multiplier and
//   accumulator registers plus the 2*WIDTH-bit adder.
//   Ports:
//     clk          in   clock, all state on rising edge
//     rst          in   synchronous, active-high reset (clears all registers)
//     load         in   capture op_a/op_b and clear the accumulator
//     step         in   perform one shift-add iteration
//     op_a         in   WIDTH    multiplicand
//     op_b         in   WIDTH    multiplier
//     product      out  2*WIDTH  accumulator contents (final product after last step)
//     mplier_zero  out  multiplier will be zero once the current step shifts it
// -----------------------------------------------------------------------------
module multu_datapath
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, op_a};
      mplier <= op_b;
      acc    <= '0;
    end else if (step) begin
      // The true product fits in 2*WIDTH bits, so this add never overflows.
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Looks at the value mplier will have after this cycle's right shift.
  assign mplier_zero = (mplier[WIDTH-1:1] == '0);
  assign product     = acc;

endmodule

// File: rtl/multu_sequencer.sv
// -----------------------------------------------------------------------------
// multu_sequencer
//   Multi-cycle controller for unsigned WIDTHxWIDTH multiply (MULTU). Accepts an
//   operand pair from EX, iterates the shift-add datapath, writes the product
//   to HiLo with a one-cycle strobe, and stalls the pipeline front end on a new
//   MULTU or an MFHI/MFLO while a multiply is in flight.
//   Optional feature: define MULTU_EARLY_TERM_EN to finish as soon as the
//   remaining multiplier bits are all zero (product unchanged).
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst      in   synchronous, active-high reset; aborts any multiply
//     start    in   EX holds a MULTU (level, held while stalled)
//     op_a     in   WIDTH  multiplicand
//     op_b     in   WIDTH  multiplier
//     hilo_rd  in   EX holds MFHI/MFLO
//     stall    out  freeze PC/IF_ID/ID_EX, bubble into EX_MEM
//     busy     out  sequencer not in IDLE
//     hilo_we  out  one-cycle HiLo write strobe
//     hi_wd    out  WIDTH  product upper half, valid with hilo_we
//     lo_wd    out  WIDTH  product lower half, valid with hilo_we
//     done     out  same as hilo_we
// -----------------------------------------------------------------------------
module multu_sequencer
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH,
  parameter int CNT_W = MULTU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wd,
  output logic [WIDTH-1:0] lo_wd,
  output logic             done
);

`ifdef MULTU_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               last_step;
  logic               mplier_zero;
  logic [2*WIDTH-1:0] product;

  // Operands are only captured in IDLE; a start seen while busy is held off
  // by stall and picked up in the IDLE cycle following DONE.
  assign load      = (state == IDLE) && start;
  assign step      = (state == RUN);
  assign last_step = (cnt == CNT_W'(WIDTH - 1)) || (EARLY_TERM && mplier_zero);

  multu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .op_a        (op_a),
    .op_b        (op_b),
    .product     (product),
    .mplier_zero (mplier_zero)
  );

  // busy and hilo_we are registered alongside state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            hilo_we <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall also covers DONE: HiLo is only written at the end of that cycle.
  assign stall = busy && (start || hilo_rd);
  assign done  = hilo_we;
  assign hi_wd = product[2*WIDTH-1:WIDTH];
  assign lo_wd = product[WIDTH-1:0];

endmodule

// File: tb/tb_multu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multu_sequencer
//   Directed bench for multu_sequencer (WIDTH=32). Cycle 0 is the cycle in
//   which start is first presented; the edge that ends it is edge 0. Expected
//   hilo_we cycles are hand-computed for both builds (MULTU_EARLY_TERM_EN).
// -----------------------------------------------------------------------------
`ifdef MULTU_EARLY_TERM_EN
`define TB_WC(n) (n)
`else
`define TB_WC(n) (33)
`endif

module tb_multu_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hilo_rd;
  logic         stall;
  logic         busy;
  logic         hilo_we;
  logic [W-1:0] hi_wd;
  logic [W-1:0] lo_wd;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  multu_sequencer #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .hilo_rd (hilo_rd),
    .stall   (stall),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_wd   (hi_wd),
    .lo_wd   (lo_wd),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc,
                       input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from an IDLE cycle; wc is the hand-computed hilo_we cycle.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rd, input logic [W-1:0] eh,
                      input logic [W-1:0] el, input int wc);
    op_a    = a;
    op_b    = b;
    start   = 1'b1;
    hilo_rd = 1'b0;
    #1;
    check("idle_stall", 0, W'(stall), W'(0));
    check("idle_busy",  0, W'(busy),  W'(0));
    for (int c = 1; c <= wc + 1; c++) begin
      tick();
      if (c == 1) begin
        start   = 1'b0;
        hilo_rd = rd;
        op_a    = ~a;   // must be ignored after the load
        op_b    = ~b;
      end
      #1;
      check("busy",    c, W'(busy),    W'(c <= wc));
      check("stall",   c, W'(stall),   W'((c <= wc) && rd));
      check("hilo_we", c, W'(hilo_we), W'(c == wc));
      check("done",    c, W'(done),    W'(c == wc));
      if (c == wc) begin
        check("hi_wd", c, hi_wd, eh);
        check("lo_wd", c, lo_wd, el);
      end
    end
    hilo_rd = 1'b0;
  endtask

  initial begin
    int wc1;
    int wc2;
    int rc;
    int last;
    logic exp_busy;
    rst     = 1'b1;
    start   = 1'b0;
    hilo_rd = 1'b0;
    op_a    = '0;
    op_b    = '0;
    tick();
    tick();
    check("rst_busy",    0, W'(busy),    W'(0));
    check("rst_stall",   0, W'(stall),   W'(0));
    check("rst_hilo_we", 0, W'(hilo_we), W'(0));
    check("rst_done",    0, W'(done),    W'(0));
    check("rst_hi",      0, hi_wd,       W'(0));
    check("rst_lo",      0, lo_wd,       W'(0));
    rst = 1'b0;
    tick();

    mult(32'd3,        32'd5,        1'b0, 32'h0,        32'd15,       `TB_WC(4));
    mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, `TB_WC(33));
    mult(32'h12345678, 32'd5,        1'b1, 32'h0,        32'h5B05B058, `TB_WC(4));
    mult(32'hDEADBEEF, 32'd0,        1'b0, 32'h0,        32'h0,        `TB_WC(2));
    mult(32'h00000001, 32'h80000000, 1'b0, 32'h0,        32'h80000000, `TB_WC(33));
    mult(32'h80000000, 32'd2,        1'b1, 32'h1,        32'h0,        `TB_WC(3));
    mult(32'h0000FFFF, 32'h00010001, 1'b0, 32'h0,        32'hFFFFFFFF, `TB_WC(18));

    // start held through a multiply: second load in the IDLE cycle after DONE.
    wc1   = `TB_WC(3);
    wc2   = wc1 + 1 + `TB_WC(4);
    last  = wc2 + 1;
    op_a  = 32'd2;
    op_b  = 32'd3;
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == 1) begin
        op_a = 32'd4;
        op_b = 32'd6;
      end
      if (c == wc1 + 2) start = 1'b0;
      #1;
      exp_busy = (c <= wc1) || (c > wc1 + 1 && c <= wc2);
      check("hold_busy",    c, W'(busy),    W'(exp_busy));
      check("hold_stall",   c, W'(stall),   W'(exp_busy && start));
      check("hold_hilo_we", c, W'(hilo_we), W'(c == wc1 || c == wc2));
      if (c == wc1) check("hold_lo1", c, lo_wd, 32'd6);
      if (c == wc2) check("hold_lo2", c, lo_wd, 32'd24);
    end

    // Reset mid-multiply of 7x9 aborts it: no write, back to IDLE.
`ifdef MULTU_EARLY_TERM_EN
    rc = 3;
`else
    rc = 5;
`endif
    op_a    = 32'd7;
    op_b    = 32'd9;
    start   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        start   = 1'b0;
        hilo_rd = 1'b1;
      end
      rst = (c == rc);
      #1;
      check("abort_hilo_we", c, W'(hilo_we), W'(0));
      check("abort_busy",    c, W'(busy),    W'(c <= rc));
      check("abort_stall",   c, W'(stall),   W'(c <= rc));
      if (c > rc) begin
        check("abort_hi", c, hi_wd, W'(0));
        check("abort_lo", c, lo_wd, W'(0));
      end
    end
    hilo_rd = 1'b0;
    tick();

    // Sequencer is usable again after the abort.
    mult(32'd7, 32'd9, 1'b0, 32'h0, 32'd63, `TB_WC(5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`undef TB_WC
